// File: rtl/io_bridge.sv
// io_bridge: sits between the CPU load/store port, a synchronous data RAM and
// a small memory-mapped I/O window holding a TX byte FIFO, a status register,
// a free-running timer and a scratch register.
//
// Ports
//   clk                    system clock
//   reset                  synchronous active-high reset
//   write_to_memory        CPU store strobe
//   mem_address_load_stor  CPU load/store address (WIDTH)
//   data_to_mem_stor       CPU store data (WIDTH)
//   data_from_mem_load     load data, one cycle after the address (WIDTH)
//   ram_we/ram_addr/ram_wdata  data RAM write port (combinational)
//   ram_rdata              data RAM read data, valid one cycle after ram_addr
//   tx_data/tx_valid       FIFO head byte and non-empty flag to the serializer
//   tx_ready               serializer takes the head byte this cycle
//
// I/O window, offsets from IO_BASE:
//   0 TXDATA (write pushes a byte, reads 0)
//   1 STATUS {count[5:3], overflow[2], full[1], empty[0]}; write bit2=1 clears overflow
//   2 TIMER  free-running, loadable
//   3 SCRATCH
module io_bridge #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] IO_BASE    = 16'hFF00,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_to_memory,
  input  logic [WIDTH-1:0] mem_address_load_stor,
  input  logic [WIDTH-1:0] data_to_mem_stor,
  output logic [WIDTH-1:0] data_from_mem_load,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam int               PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]       DEPTH_C = 4'(FIFO_DEPTH);
  localparam logic [PW-1:0]    LAST_P  = PW'(FIFO_DEPTH - 1);
  localparam logic [WIDTH-1:0] IO_LAST = IO_BASE + WIDTH'(3);

  // FIFO state
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [3:0]       r_count;
  logic             r_ovf;

  // I/O registers and read-response pipeline
  logic [WIDTH-1:0] r_timer;
  logic [WIDTH-1:0] r_scratch;
  logic             r_rd_io;
  logic [WIDTH-1:0] r_io_rdata;

  logic             w_io_hit;
  logic [WIDTH-1:0] w_delta;
  logic [1:0]       w_off;
  logic             w_wr_io;
  logic             w_push_req;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_set;
  logic             w_ovf_clr;
  logic             w_timer_wr;
  logic             w_scr_wr;
  logic [WIDTH-1:0] w_status;
  logic [WIDTH-1:0] w_io_rdata;

  assign w_io_hit = (mem_address_load_stor >= IO_BASE) && (mem_address_load_stor <= IO_LAST);
  assign w_delta  = mem_address_load_stor - IO_BASE;
  assign w_off    = w_delta[1:0];
  assign w_wr_io  = write_to_memory & w_io_hit;

  assign ram_we    = write_to_memory & ~w_io_hit;
  assign ram_addr  = mem_address_load_stor;
  assign ram_wdata = data_to_mem_stor;

  assign w_full     = (r_count == DEPTH_C);
  assign w_empty    = (r_count == 4'd0);
  assign w_push_req = w_wr_io && (w_off == 2'd0);
  assign w_push     = w_push_req & ~w_full;
  // A pop in the same cycle does not make room for a push into a full FIFO.
  assign w_pop      = tx_ready & ~w_empty;
  assign w_ovf_set  = w_push_req & w_full;
  assign w_ovf_clr  = w_wr_io && (w_off == 2'd1) && data_to_mem_stor[2];
  assign w_timer_wr = w_wr_io && (w_off == 2'd2);
  assign w_scr_wr   = w_wr_io && (w_off == 2'd3);

  assign w_status = {{(WIDTH-6){1'b0}}, r_count[2:0], r_ovf, w_full, w_empty};

  always_comb begin
    w_io_rdata = '0;
    case (w_off)
      2'd1:    w_io_rdata = w_status;
      2'd2:    w_io_rdata = r_timer;
      2'd3:    w_io_rdata = r_scratch;
      default: w_io_rdata = '0;
    endcase
  end

  // FIFO storage carries no reset; emptiness is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= data_to_mem_stor[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_timer    <= '0;
      r_scratch  <= '0;
      r_rd_io    <= 1'b0;
      r_io_rdata <= '0;
    end else begin
      if (w_push) r_tail <= (r_tail == LAST_P) ? '0 : r_tail + PW'(1);
      if (w_pop)  r_head <= (r_head == LAST_P) ? '0 : r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
      // Set has priority over a same-cycle clear.
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      r_timer <= w_timer_wr ? data_to_mem_stor : r_timer + WIDTH'(1);
      if (w_scr_wr) r_scratch <= data_to_mem_stor;
      // Register the I/O value from the address cycle, alongside its select.
      r_rd_io    <= w_io_hit;
      r_io_rdata <= w_io_rdata;
    end
  end

  // The RAM already delivers its data one cycle late, so it passes straight through.
  assign data_from_mem_load = r_rd_io ? r_io_rdata : ram_rdata;

  assign tx_valid = ~w_empty;
  assign tx_data  = r_mem[r_head];

endmodule

// File: tb/tb_io_bridge.sv
module tb_io_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic        write_to_memory;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] dout;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  io_bridge dut (
    .clk                   (clk),
    .reset                 (reset),
    .write_to_memory       (write_to_memory),
    .mem_address_load_stor (addr),
    .data_to_mem_stor      (wdata),
    .data_from_mem_load    (dout),
    .ram_we                (ram_we),
    .ram_addr              (ram_addr),
    .ram_wdata             (ram_wdata),
    .ram_rdata             (ram_rdata),
    .tx_data               (tx_data),
    .tx_valid              (tx_valid),
    .tx_ready              (tx_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] rd_exp_q[$];
  logic [7:0]  tx_exp_q[$];
  logic        load_req = 1'b0;
  logic        r_pend   = 1'b0;

  // Synchronous data RAM environment: one-cycle read latency.
  logic [15:0] tb_ram [256];
  initial begin
    for (int i = 0; i < 256; i++) tb_ram[i] = 16'h0000;
    ram_rdata = 16'h0000;
  end
  always @(posedge clk) begin
    if (ram_we) tb_ram[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= tb_ram[ram_addr[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: a load issued in one cycle is answered in the next.
  always @(posedge clk) r_pend <= reset ? 1'b0 : load_req;

  always @(negedge clk) begin
    if (r_pend) begin
      if (rd_exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected actual=%h expected=none", dout);
      end else begin
        chk("rd_data", {16'h0, dout}, {16'h0, rd_exp_q.pop_front()});
      end
    end
    if (tx_valid && tx_ready && !reset) begin
      if (tx_exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL tx_unexpected actual=%h expected=none", tx_data);
      end else begin
        chk("tx_data", {24'h0, tx_data}, {24'h0, tx_exp_q.pop_front()});
      end
    end
  end

  // One bus cycle; optionally checks the combinational ram_we mid-cycle.
  task automatic op(input logic we, input logic [15:0] a, input logic [15:0] d,
                    input logic ld, input logic [15:0] exp, input int exp_we);
    write_to_memory = we;
    addr            = a;
    wdata           = d;
    load_req        = ld;
    if (ld) rd_exp_q.push_back(exp);
    #1;
    if (exp_we >= 0) chk("ram_we", {31'h0, ram_we}, exp_we[31:0]);
    @(posedge clk); #1;
    write_to_memory = 1'b0;
    load_req        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, -1);
  endtask

  initial begin
    reset = 1'b1; write_to_memory = 1'b0; addr = 16'h0000; wdata = 16'h0000; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("reset_dout", {16'h0, dout}, 32'h0);
    reset = 1'b0;

    // RAM path
    op(1'b1, 16'h0010, 16'h1234, 1'b0, 16'h0, 1);
    op(1'b0, 16'h0010, 16'h0000, 1'b1, 16'h1234, 0);
    idle(1);

    // Window edges; the FF00 store pushes one byte that drains at once
    op(1'b1, 16'hFEFF, 16'h1111, 1'b0, 16'h0, 1);
    op(1'b1, 16'hFF04, 16'h2222, 1'b0, 16'h0, 1);
    tx_ready = 1'b1;
    tx_exp_q.push_back(8'h55);
    op(1'b1, 16'hFF00, 16'h0055, 1'b0, 16'h0, 0);
    chk("tx_valid_after_push", {31'h0, tx_valid}, 32'h1);
    idle(2);
    chk("tx_drained_one", tx_exp_q.size(), 32'h0);
    tx_ready = 1'b0;

    // Scratch
    op(1'b1, 16'hFF03, 16'hA5A5, 1'b0, 16'h0, 0);
    op(1'b0, 16'hFF03, 16'h0000, 1'b1, 16'hA5A5, 0);

    // FIFO fill and overflow
    for (int i = 0; i < 5; i++) begin
      logic [15:0] v;
      v = 16'h0041 + 16'(i);
      if (i < 4) tx_exp_q.push_back(v[7:0]);
      op(1'b1, 16'hFF00, v, 1'b0, 16'h0, 0);
    end
    op(1'b0, 16'hFF01, 16'h0000, 1'b1, 16'h0026, -1);
    op(1'b0, 16'hFF00, 16'h0000, 1'b1, 16'h0000, -1);
    op(1'b1, 16'hFF01, 16'h0004, 1'b0, 16'h0, 0);
    op(1'b0, 16'hFF01, 16'h0000, 1'b1, 16'h0022, -1);

    // Drain on consecutive cycles
    tx_ready = 1'b1;
    idle(4);
    chk("drain_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("drain_queue", tx_exp_q.size(), 32'h0);
    op(1'b0, 16'hFF01, 16'h0000, 1'b1, 16'h0001, -1);
    tx_ready = 1'b0;

    // Timer wrap: loaded with FFFE, reads 0000 three cycles after the write cycle
    op(1'b1, 16'hFF02, 16'hFFFE, 1'b0, 16'h0, 0);
    idle(2);
    op(1'b0, 16'hFF02, 16'h0000, 1'b1, 16'h0000, -1);
    idle(1);

    // Reset mid-traffic with three entries queued
    op(1'b1, 16'hFF03, 16'h5A5A, 1'b0, 16'h0, 0);
    op(1'b1, 16'hFF00, 16'h0061, 1'b0, 16'h0, 0);
    op(1'b1, 16'hFF00, 16'h0062, 1'b0, 16'h0, 0);
    op(1'b1, 16'hFF00, 16'h0063, 1'b0, 16'h0, 0);
    chk("queued_tx_valid", {31'h0, tx_valid}, 32'h1);
    reset = 1'b1;
    addr  = 16'hFF03;
    @(posedge clk); #1;
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_dout", {16'h0, dout}, 32'h0);
    write_to_memory = 1'b1; addr = 16'h0020; wdata = 16'h7777;
    #1;
    chk("rst_ram_we", {31'h0, ram_we}, 32'h1);
    chk("rst_ram_addr", {16'h0, ram_addr}, 32'h0000_0020);
    @(posedge clk); #1;
    write_to_memory = 1'b0;
    reset = 1'b0;
    op(1'b0, 16'hFF02, 16'h0000, 1'b1, 16'h0000, -1);
    op(1'b0, 16'hFF01, 16'h0000, 1'b1, 16'h0001, -1);
    op(1'b0, 16'hFF03, 16'h0000, 1'b1, 16'h0000, -1);
    idle(1);
    chk("rst_tx_valid_after", {31'h0, tx_valid}, 32'h0);

    chk("rd_queue_empty", rd_exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
